sweep_sequencer: RTL and testbench

- Sequences a stepped-frequency sweep around the I/Q phase detector.
- For each sweep point it:
  - programs the reference NCO frequency word;
  - waits a settle time;
  - brackets one integration window with two trigger pulses;
  - captures the detector's I/Q result;
  - presents the result on a valid/ready stream to the host/FIFO.
- It is the only block that drives the detector trigger.

---
 rtl/sweep_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: stepped-frequency sweep controller for the I/Q phase detector.
// Define SWEEP_SEQ_AVG_EN to average 2^AVG_LOG2 detector windows per point.
module sweep_sequencer #(
  parameter int FTW_W   = 32,
  parameter int CNT_W   = 24,
  parameter int ACC_W   = 40,
  parameter int IDX_W   = 16,
  parameter int TIMEOUT = 64
`ifdef SWEEP_SEQ_AVG_EN
  ,
  parameter int AVG_LOG2 = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FTW_W-1:0] f_start,
  input  logic [FTW_W-1:0] f_step,
  input  logic [IDX_W-1:0] n_points,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] integ_cycles,
  output logic [FTW_W-1:0] ftw,
  output logic             ftw_valid,
  output logic             pd_trigger,
  input  logic             pd_valid,
  input  logic [ACC_W-1:0] pd_i,
  input  logic [ACC_W-1:0] pd_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_index,
  output logic [ACC_W-1:0] res_i,
  output logic [ACC_W-1:0] res_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    ARM,
    INTEG,
    CLOSE,
    WAIT_RES,
    OUTPUT
  } state_t;

  state_t state, state_n;

  logic [FTW_W-1:0] step_l;
  logic [IDX_W-1:0] npts_l;
  logic [CNT_W-1:0] settle_l;
  logic [CNT_W-1:0] integ_l;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] k;

  logic [FTW_W-1:0] ftw_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] i_q;
  logic [ACC_W-1:0] q_q;
  logic             done_q;
  logic             err_q;

  logic accept;
  logic empty_start;
  logic capture;
  logic xfer;
  logic timeout;
  logic last;
  logic settle_end;
  logic integ_end;
  logic tmo_end;
  logic rep_last;

  logic [ACC_W-1:0] cap_i;
  logic [ACC_W-1:0] cap_q;

  assign last       = (k == npts_l - IDX_W'(1));
  assign settle_end = (cnt == settle_l - CNT_W'(1));
  assign integ_end  = (integ_l == '0) ||
                      (cnt == integ_l - CNT_W'(1));
  assign tmo_end    = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef SWEEP_SEQ_AVG_EN
  localparam int SW = ACC_W + AVG_LOG2;

  logic [AVG_LOG2:0]    rep;
  logic signed [SW-1:0] acc_i;
  logic signed [SW-1:0] acc_q;
  logic signed [SW-1:0] sum_i;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] avg_i;
  logic signed [SW-1:0] avg_q;

  assign rep_last = (rep == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));
  assign sum_i = acc_i + $signed({{AVG_LOG2{pd_i[ACC_W-1]}}, pd_i});
  assign sum_q = acc_q + $signed({{AVG_LOG2{pd_q[ACC_W-1]}}, pd_q});
  assign avg_i = sum_i >>> AVG_LOG2;
  assign avg_q = sum_q >>> AVG_LOG2;
  assign cap_i = avg_i[ACC_W-1:0];
  assign cap_q = avg_q[ACC_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (accept || abort || timeout) begin
      rep   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (capture) begin
      rep   <= rep_last ? '0 : rep + (AVG_LOG2+1)'(1);
      acc_i <= rep_last ? '0 : sum_i;
      acc_q <= rep_last ? '0 : sum_q;
    end
  end
`else
  assign rep_last = 1'b1;
  assign cap_i    = pd_i;
  assign cap_q    = pd_q;
`endif

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    empty_start = 1'b0;
    capture     = 1'b0;
    xfer        = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (n_points == '0) begin
            empty_start = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = LOAD;
          end
        end
      end
      LOAD:   state_n = (settle_l == '0) ? ARM : SETTLE;
      SETTLE: if (settle_end) state_n = ARM;
      ARM:    state_n = INTEG;
      INTEG:  if (integ_end) state_n = CLOSE;
      CLOSE:  state_n = WAIT_RES;
      WAIT_RES: begin
        // pd_valid outside this state is a stale window and ignored
        if (pd_valid) begin
          capture = 1'b1;
          state_n = rep_last ? OUTPUT : ARM;
        end else if (tmo_end) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          xfer    = 1'b1;
          state_n = last ? IDLE : LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n     = IDLE;
      accept      = 1'b0;
      empty_start = 1'b0;
      capture     = 1'b0;
      xfer        = 1'b0;
      timeout     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      step_l   <= '0;
      npts_l   <= '0;
      settle_l <= '0;
      integ_l  <= '0;
      ftw_q    <= '0;
      idx_q    <= '0;
      i_q      <= '0;
      q_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= (state_n != state) ? '0 : cnt + CNT_W'(1);
      done_q <= empty_start || (xfer && last);
      if (accept) begin
        ftw_q    <= f_start;
        step_l   <= f_step;
        npts_l   <= n_points;
        settle_l <= settle_cycles;
        integ_l  <= integ_cycles;
        k        <= '0;
        err_q    <= 1'b0;
      end
      // next word is ready while LOAD strobes ftw_valid
      if (xfer && !last) ftw_q <= ftw_q + step_l;
      if (xfer) k <= k + IDX_W'(1);
      if (timeout) err_q <= 1'b1;
      if (capture && rep_last) begin
        idx_q <= k;
        i_q   <= cap_i;
        q_q   <= cap_q;
      end
    end
  end

  assign ftw        = ftw_q;
  assign ftw_valid  = (state == LOAD);
  assign pd_trigger = (state == ARM) || (state == CLOSE);
  assign res_valid  = (state == OUTPUT);
  assign res_index  = idx_q;
  assign res_i      = i_q;
  assign res_q      = q_q;
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed and randomized sweeps against an arithmetic
// sweep model with a behavioural detector that also emits stale windows.
`timescale 1ns/1ps
module tb_sweep_sequencer;
  localparam int FTW_W   = 32;
  localparam int CNT_W   = 24;
  localparam int ACC_W   = 40;
  localparam int IDX_W   = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [FTW_W-1:0] f_start;
  logic [FTW_W-1:0] f_step;
  logic [IDX_W-1:0] n_points;
  logic [CNT_W-1:0] settle_cycles;
  logic [CNT_W-1:0] integ_cycles;
  logic [FTW_W-1:0] ftw;
  logic             ftw_valid;
  logic             pd_trigger;
  logic             pd_valid;
  logic [ACC_W-1:0] pd_i;
  logic [ACC_W-1:0] pd_q;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_index;
  logic [ACC_W-1:0] res_i;
  logic [ACC_W-1:0] res_q;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  sweep_sequencer #(
    .FTW_W(FTW_W), .CNT_W(CNT_W), .ACC_W(ACC_W),
    .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points),
    .settle_cycles(settle_cycles), .integ_cycles(integ_cycles),
    .ftw(ftw), .ftw_valid(ftw_valid), .pd_trigger(pd_trigger),
    .pd_valid(pd_valid), .pd_i(pd_i), .pd_q(pd_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_i(res_i), .res_q(res_q),
    .busy(busy), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [FTW_W-1:0] ftw_seen[$];
  int               ftw_cyc[$];
  int               trig_cyc[$];
  logic [IDX_W-1:0] rx_idx[$];
  logic [ACC_W-1:0] rx_i[$];
  logic [ACC_W-1:0] rx_q[$];
  logic [ACC_W-1:0] exp_i[$];
  logic [ACC_W-1:0] exp_q[$];
  int done_cnt, done_cyc, xfer_cyc, overlap, err_rise;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (ftw_valid) begin
      ftw_seen.push_back(ftw);
      ftw_cyc.push_back(cyc);
    end
    if (pd_trigger) trig_cyc.push_back(cyc);
    if (res_valid && res_ready) begin
      rx_idx.push_back(res_index);
      rx_i.push_back(res_i);
      rx_q.push_back(res_q);
      xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done && res_valid) overlap++;
    if (err && !err_prev) err_rise = cyc;
    err_prev = err;
  end

  // Detector: opening trigger -> stale pulse next cycle;
  // closing trigger -> fresh random result 3 cycles later.
  bit det_en = 1'b1;
  bit stale_en = 1'b1;
  bit det_open = 1'b0;
  int stale_cd = 0;
  int resp_cd = 0;
  logic [ACC_W-1:0] vi, vq;

  initial begin
    pd_valid = 1'b0;
    pd_i = '0;
    pd_q = '0;
    forever begin
      @(negedge clk);
      pd_valid = 1'b0;
      if (stale_cd > 0) begin
        stale_cd--;
        if (stale_cd == 0) begin
          pd_valid = 1'b1;
          pd_i = ACC_W'(32'hDEAD);
          pd_q = ACC_W'(32'hDEAD);
        end
      end
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          vi = ACC_W'({$urandom(), $urandom()});
          vq = ACC_W'({$urandom(), $urandom()});
          pd_valid = 1'b1;
          pd_i = vi;
          pd_q = vq;
          exp_i.push_back(vi);
          exp_q.push_back(vq);
        end
      end
      if (pd_trigger) begin
        if (!det_open) begin
          det_open = 1'b1;
          if (stale_en) stale_cd = 1;
        end else begin
          det_open = 1'b0;
          if (det_en) resp_cd = 3;
        end
      end
    end
  end

  bit rr_mode = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rr_mode) res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ftw_seen.delete();
    ftw_cyc.delete();
    trig_cyc.delete();
    rx_idx.delete();
    rx_i.delete();
    rx_q.delete();
    exp_i.delete();
    exp_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    xfer_cyc = -100;
    overlap = 0;
    err_rise = -1;
    det_open = 1'b0;
    stale_cd = 0;
    resp_cd = 0;
  endtask

  task automatic go(input logic [FTW_W-1:0] fs, input logic [FTW_W-1:0] st,
                    input int n, input int se, input int ig);
    @(negedge clk);
    clear_mon();
    f_start = fs;
    f_step = st;
    n_points = IDX_W'(n);
    settle_cycles = CNT_W'(se);
    integ_cycles = CNT_W'(ig);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_start = $urandom;
    f_step = $urandom;
    n_points = IDX_W'(n + 3);
    settle_cycles = CNT_W'(se + 7);
    integ_cycles = CNT_W'(ig + 5);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string tag, input logic [FTW_W-1:0] fs,
                        input logic [FTW_W-1:0] st, input int n,
                        input int se, input int ig);
    int w = (ig == 0) ? 1 : ig;
    logic [FTW_W-1:0] e;
    chk({tag, "_nftw"}, ftw_seen.size(), n);
    for (int k = 0; k < n && k < ftw_seen.size(); k++) begin
      e = fs + st * FTW_W'(k);
      chk({tag, "_ftw"}, ftw_seen[k], e);
    end
    chk({tag, "_nres"}, rx_idx.size(), n);
    chk({tag, "_nexp"}, exp_i.size(), n);
    for (int k = 0; k < rx_idx.size() && k < exp_i.size(); k++) begin
      chk({tag, "_idx"}, rx_idx[k], k);
      chk({tag, "_res_i"}, rx_i[k], exp_i[k]);
      chk({tag, "_res_q"}, rx_q[k], exp_q[k]);
    end
    chk({tag, "_ntrig"}, trig_cyc.size(), 2 * n);
    for (int k = 0; 2 * k + 1 < trig_cyc.size(); k++)
      chk({tag, "_trig_gap"}, trig_cyc[2*k+1] - trig_cyc[2*k], w + 1);
    if (ftw_cyc.size() > 0 && trig_cyc.size() > 0)
      chk({tag, "_settle"}, trig_cyc[0] - ftw_cyc[0], se + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_lat"}, done_cyc - xfer_cyc, 1);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  logic [FTW_W-1:0] fs, st;
  logic [IDX_W-1:0] s_idx;
  logic [ACC_W-1:0] s_i, s_q;
  int n, se, ig, c, n0, nt;
  bit stable;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    f_start = '0;
    f_step = '0;
    n_points = '0;
    settle_cycles = '0;
    integ_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_ftw", ftw, 0);
    chk("rst_ftw_valid", ftw_valid, 0);
    chk("rst_trigger", pd_trigger, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_index, res_i[7:0]}, 0);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // basic sweep, stale detector pulse after every ARM
    go(32'h1000_0000, 32'h0010_0000, 3, 5, 10);
    wait_idle("basic_idle", 2000);
    verify("basic", 32'h1000_0000, 32'h0010_0000, 3, 5, 10);
    if (trig_cyc.size() > 1)
      chk("basic_gap11", trig_cyc[1] - trig_cyc[0], 11);

    // wrap-around
    go(32'hFFFF_FFF0, 32'h20, 2, 0, 0);
    wait_idle("wrap_idle", 1000);
    verify("wrap", 32'hFFFF_FFF0, 32'h20, 2, 0, 0);
    chk("wrap_ftw1", (ftw_seen.size() > 1) ? ftw_seen[1] : 32'h0, 32'h10);

    // backpressure on point 0
    fs = $urandom;
    st = $urandom;
    res_ready = 1'b0;
    go(fs, st, 2, 3, 4);
    c = 0;
    while (!res_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("bp_valid", res_valid, 1);
    s_idx = res_index;
    s_i = res_i;
    s_q = res_q;
    n0 = ftw_seen.size();
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_index !== s_idx ||
          res_i !== s_i || res_q !== s_q || ftw_valid)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_ftw", ftw_seen.size(), n0);
    chk("bp_idx0", s_idx, 0);
    res_ready = 1'b1;
    wait_idle("bp_idle", 1000);
    verify("bp", fs, st, 2, 3, 4);

    // randomized sweeps with random backpressure
    rr_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fs = $urandom;
      st = $urandom;
      n = $urandom_range(1, 4);
      se = $urandom_range(0, 6);
      ig = $urandom_range(0, 8);
      go(fs, st, n, se, ig);
      wait_idle("rnd_idle", 5000);
      verify("rnd", fs, st, n, se, ig);
    end
    @(negedge clk);
    rr_mode = 1'b0;
    res_ready = 1'b1;

    // detector timeout
    det_en = 1'b0;
    go($urandom, $urandom, 2, 2, 3);
    wait_idle("tmo_idle", 1000);
    chk("tmo_err", err, 1);
    chk("tmo_done", done_cnt, 0);
    chk("tmo_nres", rx_idx.size(), 0);
    chk("tmo_ntrig", trig_cyc.size(), 2);
    if (trig_cyc.size() > 1)
      chk("tmo_latency", (err_rise - trig_cyc[1] >= TIMEOUT) &&
                         (err_rise - trig_cyc[1] <= TIMEOUT + 2), 1);
    det_en = 1'b1;

    // next accepted start clears err
    fs = $urandom;
    st = $urandom;
    go(fs, st, 1, 1, 2);
    chk("err_clear", err, 0);
    wait_idle("clr_idle", 1000);
    verify("clr", fs, st, 1, 1, 2);

    // zero points
    go($urandom, $urandom, 0, 3, 3);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    repeat (5) @(negedge clk);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_trig", trig_cyc.size(), 0);
    chk("zero_ftw", ftw_seen.size(), 0);

    // abort during integration
    fs = $urandom;
    go(fs, $urandom, 3, 2, 20);
    c = 0;
    while (trig_cyc.size() < 1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("abort_armed", trig_cyc.size(), 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_ftw", ftw, fs);
    chk("abort_err", err, 0);
    nt = trig_cyc.size();
    repeat (40) @(negedge clk);
    chk("abort_no_trig", trig_cyc.size(), nt);
    chk("abort_no_done", done_cnt, 0);

    // asynchronous reset while presenting a result
    res_ready = 1'b0;
    go($urandom, $urandom, 1, 1, 1);
    c = 0;
    while (!res_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("rst_out_valid", res_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", res_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_res", {res_i, ftw}, 0);
    @(negedge clk);
    reset = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("rst_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
